// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit:
// FSM states, opcode/funct values and datapath mux/ALU encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    WB_R,
    EXEC_I,
    WB_I,
    MEM_ADDR,
    MEM_RD,
    MEM_WR,
    MEM_WB,
    BRANCH,
    JUMP,
    HALT
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOR = 3'd5,
    ALU_SLT = 3'd6
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_RT  = 2'd0,
    SRCB_4   = 2'd1,
    SRCB_IMM = 2'd2,
    SRCB_BR  = 2'd3
  } srcb_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'd0,
    PC_ALUOUT = 2'd1,
    PC_JUMP   = 2'd2
  } pcsrc_e;

  function automatic logic is_mem_state(state_e s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mc_ctrl_alu_decode.sv
// ALU operation select for each FSM state.
// Ports: state/opcode/funct in; alu_op, illegal_funct out.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  state_e      state,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output alu_op_e     alu_op,
  output logic        illegal_funct
);

  alu_op_e r_op;
  alu_op_e i_op;
  logic    r_ok;

  always_comb begin
    r_op = ALU_ADD;
    r_ok = 1'b1;
    case (funct)
      FN_ADD:  r_op = ALU_ADD;
      FN_SUB:  r_op = ALU_SUB;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_XOR:  r_op = ALU_XOR;
      FN_NOR:  r_op = ALU_NOR;
      FN_SLT:  r_op = ALU_SLT;
      default: r_ok = 1'b0;
    endcase
  end

  always_comb begin
    i_op = ALU_ADD;
    case (opcode)
      OP_ANDI: i_op = ALU_AND;
      OP_ORI:  i_op = ALU_OR;
      OP_XORI: i_op = ALU_XOR;
      default: i_op = ALU_ADD;
    endcase
  end

  assign illegal_funct = (opcode == OP_RTYPE) && !r_ok;

  always_comb begin
    alu_op = ALU_ADD;
    case (state)
      EXEC_R:  alu_op = r_op;
      EXEC_I:  alu_op = i_op;
      BRANCH:  alu_op = ALU_SUB;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for the shared-ALU multi-cycle MIPS-subset datapath.
// In: clk, reset, inst, zero, mem_ready. Out: datapath enables/muxes.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        imm_zext,
  output logic [2:0]  alu_op,
  output logic        rf_we,
  output logic        rf_dst_sel,
  output logic        rf_wdata_sel,
  output logic        halted,
  output logic        bus_error,
  output logic        illegal
);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       berr_q, berr_d;

  logic [5:0] op;
  logic [5:0] fn;
  alu_op_e    alu_op_w;
  logic       bad_fn;
  logic       mem_st;
  logic       stall;
  logic       timeout;
  logic       dec_ill;

  logic req_w, we_w, irw_w, pcw_w;
  logic rfwe_w, ill_w;

  assign op = inst[31:26];
  assign fn = inst[5:0];

  mc_alu_decode u_alu_dec (
    .state         (state_q),
    .opcode        (op),
    .funct         (fn),
    .alu_op        (alu_op_w),
    .illegal_funct (bad_fn)
  );

  assign mem_st  = is_mem_state(state_q);
  assign stall   = mem_st && !mem_ready;
  // Last allowed wait cycle: a ready here still succeeds.
  assign timeout = stall && (wait_q == 8'(MAX_WAIT - 1));

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    berr_d  = berr_q;
    dec_ill = 1'b0;
    if (timeout) begin
      state_d = HALT;
      berr_d  = 1'b1;
    end else if (stall) begin
      wait_d = wait_q + 8'd1;
    end else begin
      unique case (state_q)
        FETCH:  state_d = DECODE;
        DECODE: begin
          if (inst == 32'h0) begin
            state_d = HALT;
          end else if (op == OP_RTYPE && !bad_fn) begin
            state_d = EXEC_R;
          end else if (op == OP_ADDI || op == OP_ANDI ||
                       op == OP_ORI  || op == OP_XORI) begin
            state_d = EXEC_I;
          end else if (op == OP_LW || op == OP_SW) begin
            state_d = MEM_ADDR;
          end else if (op == OP_BEQ || op == OP_BNE) begin
            state_d = BRANCH;
          end else if (op == OP_J) begin
            state_d = JUMP;
          end else begin
            state_d = FETCH;
            dec_ill = 1'b1;
          end
        end
        EXEC_R:   state_d = WB_R;
        WB_R:     state_d = FETCH;
        EXEC_I:   state_d = WB_I;
        WB_I:     state_d = FETCH;
        MEM_ADDR: state_d = (op == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD:   state_d = MEM_WB;
        MEM_WR:   state_d = FETCH;
        MEM_WB:   state_d = FETCH;
        BRANCH:   state_d = FETCH;
        JUMP:     state_d = FETCH;
        HALT:     state_d = HALT;
        default:  state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      berr_q  <= berr_d;
    end
  end

  always_comb begin
    req_w        = 1'b0;
    we_w         = 1'b0;
    irw_w        = 1'b0;
    pcw_w        = 1'b0;
    rfwe_w       = 1'b0;
    ill_w        = 1'b0;
    mem_addr_sel = 1'b0;
    pc_src       = PC_ALU;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_RT;
    imm_zext     = 1'b0;
    rf_dst_sel   = 1'b0;
    rf_wdata_sel = 1'b0;
    unique case (state_q)
      FETCH: begin
        req_w = 1'b1;
        if (mem_ready) begin
          irw_w     = 1'b1;
          pcw_w     = 1'b1;
          alu_src_b = SRCB_4;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_BR;
        ill_w     = dec_ill;
      end
      EXEC_R: alu_src_a = 1'b1;
      WB_R: begin
        rfwe_w     = 1'b1;
        rf_dst_sel = 1'b1;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        imm_zext  = (op != OP_ADDI);
      end
      WB_I: rfwe_w = 1'b1;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        req_w        = 1'b1;
        mem_addr_sel = 1'b1;
      end
      MEM_WR: begin
        req_w        = 1'b1;
        we_w         = 1'b1;
        mem_addr_sel = 1'b1;
      end
      MEM_WB: begin
        rfwe_w       = 1'b1;
        rf_wdata_sel = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = PC_ALUOUT;
        pcw_w     = (op == OP_BEQ) ? zero : !zero;
      end
      JUMP: begin
        pcw_w  = 1'b1;
        pc_src = PC_JUMP;
      end
      HALT: ;
      default: ;
    endcase
  end

  // Strobes are forced low for the whole reset window.
  assign mem_req   = req_w  && !reset;
  assign mem_we    = we_w   && !reset;
  assign ir_write  = irw_w  && !reset;
  assign pc_write  = pcw_w  && !reset;
  assign rf_we     = rfwe_w && !reset;
  assign illegal   = ill_w  && !reset;
  assign alu_op    = alu_op_w;
  assign halted    = (state_q == HALT);
  assign bus_error = berr_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MAX_WAIT=8).
// Checks per-state control vectors, handshake, halt and watchdog.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel;
  logic        ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        imm_zext;
  logic [2:0]  alu_op;
  logic        rf_we, rf_dst_sel, rf_wdata_sel;
  logic        halted, bus_error, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MAX_WAIT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst         (inst),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .imm_zext     (imm_zext),
    .alu_op       (alu_op),
    .rf_we        (rf_we),
    .rf_dst_sel   (rf_dst_sel),
    .rf_wdata_sel (rf_wdata_sel),
    .halted       (halted),
    .bus_error    (bus_error),
    .illegal      (illegal)
  );

  logic [16:0] ctl;
  logic [5:0]  strb;
  assign ctl = {mem_req, mem_we, mem_addr_sel,
                ir_write, pc_write, pc_src,
                alu_src_a, alu_src_b, imm_zext,
                alu_op, rf_we, rf_dst_sel,
                rf_wdata_sel};
  assign strb = {mem_req, mem_we, ir_write,
                 pc_write, rf_we, illegal};

  function automatic logic [16:0] cv(
    logic rq, logic we, logic as,
    logic iw, logic pw, logic [1:0] ps,
    logic sa, logic [1:0] sb, logic zx,
    logic [2:0] op, logic rw, logic ds,
    logic ws);
    return {rq, we, as, iw, pw, ps, sa,
            sb, zx, op, rw, ds, ws};
  endfunction

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(logic [31:0] i,
                     logic z, logic r);
    @(negedge clk);
    reset = 1'b0;
    inst = i;
    zero = z;
    mem_ready = r;
    #1;
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk({tag, "_strb"}, 32'(strb), 0);
    chk({tag, "_halt"}, 32'(halted), 0);
    chk({tag, "_berr"}, 32'(bus_error), 0);
  endtask

  localparam logic [31:0] I_ADD = 32'h00432820;
  localparam logic [31:0] I_SLT = 32'h0043282a;
  localparam logic [31:0] I_LW  = 32'h8c060000;
  localparam logic [31:0] I_SW  = 32'hac060004;
  localparam logic [31:0] I_ORI = 32'h34a500ff;
  localparam logic [31:0] I_BEQ = 32'h1042ffff;
  localparam logic [31:0] I_BNE = 32'h1442ffff;
  localparam logic [31:0] I_J   = 32'h08000010;
  localparam logic [31:0] I_BAD = 32'hfc000000;

  logic [16:0] C_FET, C_WAIT, C_DEC, C_MRD;

  initial begin
    C_FET  = cv(1,0,0,1,1,0,0,1,0,0,0,0,0);
    C_WAIT = cv(1,0,0,0,0,0,0,0,0,0,0,0,0);
    C_DEC  = cv(0,0,0,0,0,0,0,3,0,0,0,0,0);
    C_MRD  = cv(1,0,1,0,0,0,0,0,0,0,0,0,0);

    do_reset("rst0");

    // add: 4 cycles
    cyc(I_ADD, 0, 1); chk("add_f", 32'(ctl), 32'(C_FET));
    cyc(I_ADD, 0, 1); chk("add_d", 32'(ctl), 32'(C_DEC));
    chk("add_d_ill", 32'(illegal), 0);
    cyc(I_ADD, 0, 1);
    chk("add_ex", 32'(ctl),
        32'(cv(0,0,0,0,0,0,1,0,0,0,0,0,0)));
    cyc(I_ADD, 0, 1);
    chk("add_wb", 32'(ctl),
        32'(cv(0,0,0,0,0,0,0,0,0,0,1,1,0)));

    // lw with 3 wait cycles in MEM_RD: 8 cycles
    cyc(I_LW, 0, 1); chk("lw_f", 32'(ctl), 32'(C_FET));
    cyc(I_LW, 0, 1); chk("lw_d", 32'(ctl), 32'(C_DEC));
    cyc(I_LW, 0, 1);
    chk("lw_addr", 32'(ctl),
        32'(cv(0,0,0,0,0,0,1,2,0,0,0,0,0)));
    for (int k = 0; k < 3; k++) begin
      cyc(I_LW, 0, 0);
      chk("lw_rd_wait", 32'(ctl), 32'(C_MRD));
    end
    cyc(I_LW, 0, 1); chk("lw_rd", 32'(ctl), 32'(C_MRD));
    cyc(I_LW, 0, 1);
    chk("lw_wb", 32'(ctl),
        32'(cv(0,0,0,0,0,0,0,0,0,0,1,0,1)));

    // sw: 4 cycles
    cyc(I_SW, 0, 1); chk("sw_f", 32'(ctl), 32'(C_FET));
    cyc(I_SW, 0, 1); chk("sw_d", 32'(ctl), 32'(C_DEC));
    cyc(I_SW, 0, 1);
    chk("sw_addr", 32'(ctl),
        32'(cv(0,0,0,0,0,0,1,2,0,0,0,0,0)));
    cyc(I_SW, 0, 1);
    chk("sw_wr", 32'(ctl),
        32'(cv(1,1,1,0,0,0,0,0,0,0,0,0,0)));

    // ori: zero-extended imm, OR
    cyc(I_ORI, 0, 1); chk("ori_f", 32'(ctl), 32'(C_FET));
    cyc(I_ORI, 0, 1); chk("ori_d", 32'(ctl), 32'(C_DEC));
    cyc(I_ORI, 0, 1);
    chk("ori_ex", 32'(ctl),
        32'(cv(0,0,0,0,0,0,1,2,1,3,0,0,0)));
    cyc(I_ORI, 0, 1);
    chk("ori_wb", 32'(ctl),
        32'(cv(0,0,0,0,0,0,0,0,0,0,1,0,0)));

    // beq taken, bne not taken (zero=1)
    cyc(I_BEQ, 1, 1); chk("beq_f", 32'(ctl), 32'(C_FET));
    cyc(I_BEQ, 1, 1); chk("beq_d", 32'(ctl), 32'(C_DEC));
    cyc(I_BEQ, 1, 1);
    chk("beq_br", 32'(ctl),
        32'(cv(0,0,0,0,1,1,1,0,0,1,0,0,0)));
    cyc(I_BNE, 1, 1); chk("bne_f", 32'(ctl), 32'(C_FET));
    cyc(I_BNE, 1, 1); chk("bne_d", 32'(ctl), 32'(C_DEC));
    cyc(I_BNE, 1, 1);
    chk("bne_br", 32'(ctl),
        32'(cv(0,0,0,0,0,1,1,0,0,1,0,0,0)));

    // j
    cyc(I_J, 0, 1); chk("j_f", 32'(ctl), 32'(C_FET));
    cyc(I_J, 0, 1); chk("j_d", 32'(ctl), 32'(C_DEC));
    cyc(I_J, 0, 1);
    chk("j_jmp", 32'(ctl),
        32'(cv(0,0,0,0,1,2,0,0,0,0,0,0,0)));

    // illegal opcode: one-cycle pulse, back to fetch
    cyc(I_BAD, 0, 1); chk("bad_f", 32'(ctl), 32'(C_FET));
    cyc(I_BAD, 0, 1);
    chk("bad_ill", 32'(illegal), 1);
    chk("bad_d", 32'(ctl), 32'(C_DEC));
    cyc(I_BAD, 0, 1);
    chk("bad_ill_off", 32'(illegal), 0);
    chk("bad_refetch", 32'(ctl), 32'(C_FET));

    // slt then reset during WB_R: no write
    cyc(I_SLT, 0, 1); chk("slt_d", 32'(ctl), 32'(C_DEC));
    cyc(I_SLT, 0, 1);
    chk("slt_ex", 32'(ctl),
        32'(cv(0,0,0,0,0,0,1,0,0,6,0,0,0)));
    do_reset("rst_mid");
    cyc(I_ADD, 0, 1);
    chk("rst_mid_f", 32'(ctl), 32'(C_FET));

    // halt on all-zero instruction
    cyc(32'h0, 0, 1); chk("halt_d", 32'(ctl), 32'(C_DEC));
    for (int k = 0; k < 20; k++) begin
      cyc(32'h0, 0, 1);
      chk("halt_ctl", 32'(ctl), 0);
      chk("halt_flag", 32'(halted), 1);
    end
    chk("halt_berr", 32'(bus_error), 0);
    do_reset("rst_halt");

    // watchdog: 8 wait cycles then HALT+bus_error
    for (int k = 0; k < 8; k++) begin
      cyc(I_ADD, 0, 0);
      chk("wd_wait", 32'(ctl), 32'(C_WAIT));
      chk("wd_flags", 32'({halted, bus_error}), 0);
    end
    cyc(I_ADD, 0, 0);
    chk("wd_flags9", 32'({halted, bus_error}), 3);
    chk("wd_req9", 32'(mem_req), 0);
    do_reset("rst_wd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
